// File: rtl/cell_flood_opener_if.sv
// cell_flood_opener_if: request/response and cell-array port bundle for the flood opener.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

interface cell_flood_opener_if #(
  parameter int MAX_CELL_WIDTH  = 30,
  parameter int MAX_CELL_HEIGHT = 16
);
  localparam int CELL_X_WIDTH = $clog2(MAX_CELL_WIDTH);
  localparam int CELL_Y_WIDTH = $clog2(MAX_CELL_HEIGHT);
  localparam int CELL_COUNT   = MAX_CELL_WIDTH * MAX_CELL_HEIGHT;
  localparam int CNT_WIDTH    = $clog2(CELL_COUNT + 1);

  logic                    start_i;
  logic [CELL_X_WIDTH-1:0] seed_x_i;
  logic [CELL_Y_WIDTH-1:0] seed_y_i;
  logic [CELL_X_WIDTH-1:0] field_width_i;
  logic [CELL_Y_WIDTH-1:0] field_height_i;
  logic [CELL_X_WIDTH-1:0] rd_x_o;
  logic [CELL_Y_WIDTH-1:0] rd_y_o;
  logic [3:0]              rd_state_i;
  logic [1:0]              rd_vis_i;
  logic                    wr_en_o;
  logic [CELL_X_WIDTH-1:0] wr_x_o;
  logic [CELL_Y_WIDTH-1:0] wr_y_o;
  logic                    busy_o;
  logic                    done_o;
  logic                    mine_hit_o;
  logic [CNT_WIDTH-1:0]    opened_cnt_o;
  logic                    overflow_o;

  modport master (
    output start_i, seed_x_i, seed_y_i, field_width_i, field_height_i,
    output rd_state_i, rd_vis_i,
    input  rd_x_o, rd_y_o, wr_en_o, wr_x_o, wr_y_o,
    input  busy_o, done_o, mine_hit_o, opened_cnt_o, overflow_o
  );

  modport slave (
    input  start_i, seed_x_i, seed_y_i, field_width_i, field_height_i,
    input  rd_state_i, rd_vis_i,
    output rd_x_o, rd_y_o, wr_en_o, wr_x_o, wr_y_o,
    output busy_o, done_o, mine_hit_o, opened_cnt_o, overflow_o
  );
endinterface

`default_nettype wire

// File: rtl/cell_flood_opener.sv
// cell_flood_opener: opens a seed cell and stack-floods empty regions of the minefield.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

module cell_flood_opener #(
  parameter int MAX_CELL_WIDTH  = 30,
  parameter int MAX_CELL_HEIGHT = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  cell_flood_opener_if.slave bus
);
  localparam int CELL_X_WIDTH = $clog2(MAX_CELL_WIDTH);
  localparam int CELL_Y_WIDTH = $clog2(MAX_CELL_HEIGHT);
  localparam int CELL_COUNT   = MAX_CELL_WIDTH * MAX_CELL_HEIGHT;
  localparam int CNT_WIDTH    = $clog2(CELL_COUNT + 1);

  localparam logic [3:0] STATE_EMPTY = 4'd0;
  localparam logic [3:0] STATE_MINE  = 4'd10;
  localparam logic [1:0] VIS_CLOSE   = 2'd0;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CHECK_SEED = 3'd1,
    POP        = 3'd2,
    SCAN       = 3'd3,
    DONE       = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [CELL_X_WIDTH-1:0] seed_x, cen_x, rd_x;
  logic [CELL_Y_WIDTH-1:0] seed_y, cen_y, rd_y;
  logic [2:0]              k;
  logic [CNT_WIDTH-1:0]    sp, sp_nx, opened_cnt;
  logic                    mine_flag, overflow;
  logic                    wr_en, push, set_mine, full;

  logic [CELL_X_WIDTH-1:0] stack_x [CELL_COUNT];
  logic [CELL_Y_WIDTH-1:0] stack_y [CELL_COUNT];

  logic [CELL_X_WIDTH:0]   nb_x;
  logic [CELL_Y_WIDTH:0]   nb_y;
  logic                    x_under, y_under, nb_valid;

  assign full = (sp == CNT_WIDTH'(CELL_COUNT));

  // Underflow is flagged from the centre coordinate before the subtraction happens.
  always_comb begin
    nb_x    = {1'b0, cen_x};
    nb_y    = {1'b0, cen_y};
    x_under = 1'b0;
    y_under = 1'b0;
    case (k)
      3'd0, 3'd3, 3'd5: begin
        x_under = (cen_x == '0);
        nb_x    = {1'b0, cen_x} - (CELL_X_WIDTH+1)'(1);
      end
      3'd2, 3'd4, 3'd7: nb_x = {1'b0, cen_x} + (CELL_X_WIDTH+1)'(1);
      default: ;
    endcase
    case (k)
      3'd0, 3'd1, 3'd2: begin
        y_under = (cen_y == '0);
        nb_y    = {1'b0, cen_y} - (CELL_Y_WIDTH+1)'(1);
      end
      3'd5, 3'd6, 3'd7: nb_y = {1'b0, cen_y} + (CELL_Y_WIDTH+1)'(1);
      default: ;
    endcase
    nb_valid = !x_under && !y_under &&
               (nb_x < {1'b0, bus.field_width_i}) &&
               (nb_y < {1'b0, bus.field_height_i});
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rd_x     = seed_x;
    rd_y     = seed_y;
    wr_en    = 1'b0;
    push     = 1'b0;
    set_mine = 1'b0;
    sp_nx    = sp;
    case (state)
      IDLE: begin
        if (bus.start_i) state_nx = CHECK_SEED;
      end
      CHECK_SEED: begin
        state_nx = DONE;
        if (bus.rd_vis_i == VIS_CLOSE) begin
          wr_en = 1'b1;
          if (bus.rd_state_i == STATE_MINE) begin
            set_mine = 1'b1;
          end else if (bus.rd_state_i == STATE_EMPTY) begin
            push     = 1'b1;
            state_nx = POP;
          end
        end
      end
      POP: begin
        rd_x     = cen_x;
        rd_y     = cen_y;
        sp_nx    = sp - CNT_WIDTH'(1);
        state_nx = SCAN;
      end
      SCAN: begin
        rd_x = cen_x;
        rd_y = cen_y;
        if (nb_valid) begin
          rd_x = nb_x[CELL_X_WIDTH-1:0];
          rd_y = nb_y[CELL_Y_WIDTH-1:0];
          if (bus.rd_vis_i == VIS_CLOSE) begin
            wr_en = 1'b1;
            push  = (bus.rd_state_i == STATE_EMPTY);
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // A push on a full stack is dropped; the cell is still opened.
    if (push && !full) sp_nx = sp + CNT_WIDTH'(1);
    if (state == SCAN && k == 3'd7) state_nx = (sp_nx != '0) ? POP : DONE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      seed_x     <= '0;
      seed_y     <= '0;
      cen_x      <= '0;
      cen_y      <= '0;
      k          <= '0;
      sp         <= '0;
      opened_cnt <= '0;
      mine_flag  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      sp <= sp_nx;
      if (state == IDLE && bus.start_i) begin
        seed_x     <= bus.seed_x_i;
        seed_y     <= bus.seed_y_i;
        opened_cnt <= '0;
        mine_flag  <= 1'b0;
      end
      if (wr_en)          opened_cnt <= opened_cnt + CNT_WIDTH'(1);
      if (set_mine)       mine_flag  <= 1'b1;
      if (push && full)   overflow   <= 1'b1;
      if (state == POP) begin
        cen_x <= stack_x[sp - CNT_WIDTH'(1)];
        cen_y <= stack_y[sp - CNT_WIDTH'(1)];
        k     <= '0;
      end else if (state == SCAN) begin
        k <= k + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      stack_x[sp] <= rd_x;
      stack_y[sp] <= rd_y;
    end
  end

  assign bus.rd_x_o       = rd_x;
  assign bus.rd_y_o       = rd_y;
  assign bus.wr_en_o      = wr_en;
  assign bus.wr_x_o       = rd_x;
  assign bus.wr_y_o       = rd_y;
  assign bus.busy_o       = (state != IDLE);
  assign bus.done_o       = (state == DONE);
  assign bus.mine_hit_o   = (state == DONE) && mine_flag;
  assign bus.opened_cnt_o = opened_cnt;
  assign bus.overflow_o   = overflow;

endmodule

`default_nettype wire

// File: tb/tb_cell_flood_opener.sv
// tb_cell_flood_opener: directed scenarios against a behavioural cell array.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_cell_flood_opener;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cell_flood_opener_if #(.MAX_CELL_WIDTH(30), .MAX_CELL_HEIGHT(16)) ifc ();

  cell_flood_opener #(.MAX_CELL_WIDTH(30), .MAX_CELL_HEIGHT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  logic [3:0] cst  [0:31][0:15];
  logic [1:0] vis  [0:31][0:15];
  int         wcnt [0:31][0:15];
  logic [4:0] fw;
  logic [3:0] fh;
  int total, oob, checks, errors;
  int done_cyc, ndone;
  logic mine_seen, wr_c1;

  assign ifc.rd_state_i = cst[ifc.rd_x_o][ifc.rd_y_o];
  assign ifc.rd_vis_i   = vis[ifc.rd_x_o][ifc.rd_y_o];

  task automatic clear_field(input logic [4:0] w, input logic [3:0] h);
    for (int x = 0; x < 32; x++)
      for (int y = 0; y < 16; y++) begin
        cst[x][y] = 4'd0; vis[x][y] = 2'd0; wcnt[x][y] = 0;
      end
    total = 0; oob = 0; fw = w; fh = h;
  endtask

  // One clock; the array absorbs the write that was presented during the cycle.
  task automatic step();
    logic pw; logic [4:0] px; logic [3:0] py;
    pw = ifc.wr_en_o; px = ifc.wr_x_o; py = ifc.wr_y_o;
    @(posedge clk); #1;
    if (pw) begin
      if (px >= fw || py >= fh) oob++;
      else begin wcnt[px][py]++; vis[px][py] = 2'd1; total++; end
    end
    #1;
  endtask

  task automatic run_open(input logic [4:0] sx, input logic [3:0] sy,
                          input int pulse_cyc, input int abort_cyc);
    int cyc;
    done_cyc = -1; mine_seen = 1'b0; wr_c1 = 1'b0; ndone = 0;
    ifc.seed_x_i = sx; ifc.seed_y_i = sy;
    ifc.field_width_i = fw; ifc.field_height_i = fh;
    ifc.start_i = 1'b1; step(); ifc.start_i = 1'b0;
    cyc = 1;
    while (cyc < 2000) begin
      if (ifc.done_o) begin
        ndone++;
        if (done_cyc < 0) begin done_cyc = cyc; mine_seen = ifc.mine_hit_o; end
      end
      if (cyc == 1) wr_c1 = ifc.wr_en_o;
      if (done_cyc >= 0 && cyc >= done_cyc + 5) break;
      if (cyc == pulse_cyc) ifc.start_i = 1'b1;
      if (cyc == abort_cyc) rst = 1'b0;
      step(); ifc.start_i = 1'b0;
      if (cyc == abort_cyc) break;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; ifc.start_i = 1'b0;
    clear_field(5'd5, 4'd5);
    ifc.seed_x_i = '0; ifc.seed_y_i = '0;
    ifc.field_width_i = fw; ifc.field_height_i = fh;
    repeat (3) step();
    checks++; if (ifc.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", ifc.busy_o); end
    checks++; if (ifc.done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", ifc.done_o); end
    checks++; if (ifc.wr_en_o !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", ifc.wr_en_o); end
    checks++; if (ifc.opened_cnt_o !== 9'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", ifc.opened_cnt_o); end
    checks++; if (ifc.overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ifc.overflow_o); end
    rst = 1'b1; step();
  endtask

  task automatic test_digit_seed();
    clear_field(5'd5, 4'd5);
    cst[2][2] = 4'd3;
    run_open(5'd2, 4'd2, -1, -1);
    checks++; if (wr_c1 !== 1'b1) begin errors++; $display("FAIL digit_wr_c1 got %b exp 1", wr_c1); end
    checks++; if (wcnt[2][2] != 1 || total != 1) begin errors++; $display("FAIL digit_writes got %0d/%0d exp 1/1", wcnt[2][2], total); end
    checks++; if (done_cyc != 2) begin errors++; $display("FAIL digit_done_cyc got %0d exp 2", done_cyc); end
    checks++; if (ifc.opened_cnt_o !== 9'd1) begin errors++; $display("FAIL digit_cnt got %0d exp 1", ifc.opened_cnt_o); end
    checks++; if (mine_seen !== 1'b0) begin errors++; $display("FAIL digit_mine got %b exp 0", mine_seen); end
  endtask

  task automatic test_mine_seed();
    clear_field(5'd5, 4'd5);
    cst[1][3] = 4'd10;
    run_open(5'd1, 4'd3, -1, -1);
    checks++; if (total != 1 || wcnt[1][3] != 1) begin errors++; $display("FAIL mine_writes got %0d exp 1", total); end
    checks++; if (done_cyc != 2) begin errors++; $display("FAIL mine_done_cyc got %0d exp 2", done_cyc); end
    checks++; if (mine_seen !== 1'b1) begin errors++; $display("FAIL mine_hit got %b exp 1", mine_seen); end
    checks++; if (ifc.opened_cnt_o !== 9'd1) begin errors++; $display("FAIL mine_cnt got %0d exp 1", ifc.opened_cnt_o); end
  endtask

  task automatic test_flood_3x3();
    int bad;
    clear_field(5'd3, 4'd3);
    run_open(5'd1, 4'd1, -1, -1);
    bad = 0;
    for (int x = 0; x < 3; x++) for (int y = 0; y < 3; y++) if (wcnt[x][y] != 1) bad++;
    checks++; if (bad != 0 || total != 9) begin errors++; $display("FAIL flood3_cells got %0d bad, %0d total exp 0, 9", bad, total); end
    checks++; if (done_cyc != 83) begin errors++; $display("FAIL flood3_done_cyc got %0d exp 83", done_cyc); end
    checks++; if (ifc.opened_cnt_o !== 9'd9) begin errors++; $display("FAIL flood3_cnt got %0d exp 9", ifc.opened_cnt_o); end
    checks++; if (ifc.overflow_o !== 1'b0) begin errors++; $display("FAIL flood3_ovf got %b exp 0", ifc.overflow_o); end
    checks++; if (oob != 0) begin errors++; $display("FAIL flood3_oob got %0d exp 0", oob); end
  endtask

  task automatic test_flood_boundary();
    clear_field(5'd4, 4'd4);
    cst[3][3] = 4'd10;
    cst[2][2] = 4'd1; cst[3][2] = 4'd1; cst[2][3] = 4'd1;
    vis[1][0] = 2'd2;
    run_open(5'd0, 4'd0, -1, -1);
    checks++; if (oob != 0) begin errors++; $display("FAIL bnd_oob got %0d exp 0", oob); end
    checks++; if (wcnt[1][0] != 0) begin errors++; $display("FAIL bnd_flag_written got %0d exp 0", wcnt[1][0]); end
    checks++; if (wcnt[3][3] != 0) begin errors++; $display("FAIL bnd_mine_written got %0d exp 0", wcnt[3][3]); end
    checks++; if (total != 14) begin errors++; $display("FAIL bnd_total got %0d exp 14", total); end
    checks++; if (ifc.opened_cnt_o !== 9'd14) begin errors++; $display("FAIL bnd_cnt got %0d exp 14", ifc.opened_cnt_o); end
    checks++; if (done_cyc != 101) begin errors++; $display("FAIL bnd_done_cyc got %0d exp 101", done_cyc); end
    checks++; if (wcnt[2][2] != 1 || wcnt[3][2] != 1 || wcnt[2][3] != 1) begin errors++; $display("FAIL bnd_digits got %0d%0d%0d exp 111", wcnt[2][2], wcnt[3][2], wcnt[2][3]); end
  endtask

  task automatic test_open_seed();
    clear_field(5'd5, 4'd5);
    vis[2][2] = 2'd1;
    run_open(5'd2, 4'd2, -1, -1);
    checks++; if (total != 0) begin errors++; $display("FAIL open_writes got %0d exp 0", total); end
    checks++; if (done_cyc != 2) begin errors++; $display("FAIL open_done_cyc got %0d exp 2", done_cyc); end
    checks++; if (ifc.opened_cnt_o !== 9'd0) begin errors++; $display("FAIL open_cnt got %0d exp 0", ifc.opened_cnt_o); end
  endtask

  task automatic test_start_while_busy();
    clear_field(5'd3, 4'd3);
    run_open(5'd1, 4'd1, 20, -1);
    checks++; if (ndone != 1) begin errors++; $display("FAIL busy_done_count got %0d exp 1", ndone); end
    checks++; if (done_cyc != 83) begin errors++; $display("FAIL busy_done_cyc got %0d exp 83", done_cyc); end
    checks++; if (ifc.opened_cnt_o !== 9'd9) begin errors++; $display("FAIL busy_cnt got %0d exp 9", ifc.opened_cnt_o); end
  endtask

  task automatic test_abort();
    clear_field(5'd3, 4'd3);
    run_open(5'd1, 4'd1, -1, 5);
    checks++; if (ifc.busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", ifc.busy_o); end
    checks++; if (ifc.wr_en_o !== 1'b0) begin errors++; $display("FAIL abort_wr_en got %b exp 0", ifc.wr_en_o); end
    checks++; if (dut.sp !== 9'd0) begin errors++; $display("FAIL abort_sp got %0d exp 0", dut.sp); end
    checks++; if (ndone != 0) begin errors++; $display("FAIL abort_done got %0d exp 0", ndone); end
    rst = 1'b1; step();
    clear_field(5'd5, 4'd5);
    cst[0][0] = 4'd2;
    run_open(5'd0, 4'd0, -1, -1);
    checks++; if (done_cyc != 2) begin errors++; $display("FAIL abort_restart_cyc got %0d exp 2", done_cyc); end
    checks++; if (ifc.opened_cnt_o !== 9'd1 || total != 1) begin errors++; $display("FAIL abort_restart_cnt got %0d exp 1", ifc.opened_cnt_o); end
  endtask

  initial begin
    checks = 0; errors = 0;
    ifc.start_i = 1'b0;
    test_reset();
    test_digit_seed();
    test_mine_seed();
    test_flood_3x3();
    test_flood_boundary();
    test_open_seed();
    test_start_while_busy();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
